// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input pin and measurement results of pwm_capture.
// master = capture block (produces measurements), slave = consumer/driver of pwm_in.
`default_nettype none

interface pwm_capture_if #(
  parameter int WIDTH = 16
);
  logic             pwm_in;
  logic [WIDTH-1:0] high_cnt;
  logic [WIDTH-1:0] period_cnt;
  logic             meas_valid;
  logic             timeout;
  logic [3:0]       duty;
  logic             duty_valid;

  modport master (
    input  pwm_in,
    output high_cnt, period_cnt, meas_valid, timeout, duty, duty_valid
  );

  modport slave (
    output pwm_in,
    input  high_cnt, period_cnt, meas_valid, timeout, duty, duty_valid
  );
endinterface

`default_nettype wire

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input.
// Optional 4-bit duty divider enabled by macro PWM_CAPTURE_DUTY_EN.
`default_nettype none

module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  pwm_capture_if.master cap
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, high_cnt_q, period_cnt_q;
  logic             meas_valid_q, timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= cap.pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rise)
      cnt_d = WIDTH'(1);
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + WIDTH'(1);
  end

  // A qualifying edge takes priority over the timeout when both land on the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      meas_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q   <= HIGH;
            timeout_q <= 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            hcnt_q  <= cnt_q;
            state_q <= LOW;
          end else if (cnt_q == CNT_MAX) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            period_cnt_q <= cnt_q;
            high_cnt_q   <= hcnt_q;
            meas_valid_q <= 1'b1;
            state_q      <= HIGH;
          end else if (cnt_q == CNT_MAX) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cap.high_cnt   = high_cnt_q;
  assign cap.period_cnt = period_cnt_q;
  assign cap.meas_valid = meas_valid_q;
  assign cap.timeout    = timeout_q;

`ifdef PWM_CAPTURE_DUTY_EN
  logic             div_busy_q;
  logic [1:0]       div_step_q;
  logic [WIDTH-1:0] div_rem_q, div_den_q;
  logic [3:0]       div_quo_q, duty_q;
  logic             duty_valid_q;
  logic [WIDTH-1:0] rem_src, den_src, rem_d;
  logic [WIDTH:0]   shift, diff;
  logic [3:0]       quo_src, quo_d;
  logic             ge;

  // high_cnt < period_cnt, so the partial remainder always fits WIDTH bits.
  always_comb begin
    rem_src = meas_valid_q ? high_cnt_q   : div_rem_q;
    den_src = meas_valid_q ? period_cnt_q : div_den_q;
    quo_src = meas_valid_q ? 4'd0         : div_quo_q;
    shift   = {rem_src, 1'b0};
    diff    = shift - {1'b0, den_src};
    ge      = (shift >= {1'b0, den_src});
    rem_d   = ge ? WIDTH'(diff) : WIDTH'(shift);
    quo_d   = {quo_src[2:0], ge};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_busy_q   <= 1'b0;
      div_step_q   <= 2'd0;
      div_rem_q    <= '0;
      div_den_q    <= '0;
      div_quo_q    <= 4'd0;
      duty_q       <= 4'd0;
      duty_valid_q <= 1'b0;
    end else begin
      duty_valid_q <= 1'b0;
      if (meas_valid_q) begin
        div_busy_q <= 1'b1;
        div_step_q <= 2'd1;
        div_rem_q  <= rem_d;
        div_quo_q  <= quo_d;
        div_den_q  <= period_cnt_q;
      end else if (div_busy_q) begin
        div_rem_q <= rem_d;
        div_quo_q <= quo_d;
        if (div_step_q == 2'd3) begin
          div_busy_q   <= 1'b0;
          duty_q       <= quo_d;
          duty_valid_q <= 1'b1;
        end else begin
          div_step_q <= div_step_q + 2'd1;
        end
      end
    end
  end

  assign cap.duty       = duty_q;
  assign cap.duty_valid = duty_valid_q;
`else
  assign cap.duty       = 4'd0;
  assign cap.duty_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed + random PWM stimulus against an edge-timing reference model.
`default_nettype none

module tb_pwm_capture;
  localparam int W    = 8;
  localparam int MAXV = 255;
  localparam int NC   = 16384;
`ifdef PWM_CAPTURE_DUTY_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pwm_capture_if #(.WIDTH(W)) bus ();
  pwm_capture #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .cap(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected output events, indexed by the negedge at which they become visible.
  bit ev_mv    [NC];
  bit ev_toset [NC];
  bit ev_toclr [NC];
  int ev_h     [NC];
  int ev_p     [NC];

  int cyc = 0, rst_idx = 0, r0 = 0, hq = 0;
  bit have_ref = 0, in_low = 0, last_v = 0;
  int exp_h = 0, exp_p = 0, exp_duty = 0;
  bit exp_to = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // A pin edge driven at index t is seen by the DUT's edge detector 3 negedges later.
  task automatic model_drive(input bit v);
    int d;
    bit rise, fall;
    rise = v & ~last_v;
    fall = ~v & last_v;
    if (!have_ref) begin
      if (rise) begin
        have_ref = 1; r0 = cyc; in_low = 0;
        ev_toclr[cyc+3] = 1;
      end
    end else begin
      d = cyc - r0;
      if (!in_low) begin
        if (fall) begin
          hq = (d > MAXV) ? MAXV : d;
          in_low = 1;
        end else if (d >= MAXV) begin
          ev_toset[cyc+3] = 1; have_ref = 0;
        end
      end else begin
        if (rise) begin
          ev_mv[cyc+3] = 1;
          ev_h[cyc+3]  = hq;
          ev_p[cyc+3]  = (d > MAXV) ? MAXV : d;
          r0 = cyc; in_low = 0;
        end else if (d >= MAXV) begin
          ev_toset[cyc+3] = 1; have_ref = 0;
        end
      end
    end
    last_v = v;
  endtask

  task automatic check_cycle();
    bit dv;
    dv = 0;
    if (ev_mv[cyc]) begin
      exp_h = ev_h[cyc];
      exp_p = ev_p[cyc];
    end
    if (ev_toset[cyc]) exp_to = 1;
    if (ev_toclr[cyc]) exp_to = 0;
    if (DUTY_EN && cyc - 4 >= rst_idx) begin
      if (ev_mv[cyc-4] && !ev_mv[cyc-3] && !ev_mv[cyc-2] && !ev_mv[cyc-1]) begin
        dv = 1;
        exp_duty = (16 * ev_h[cyc-4]) / ev_p[cyc-4];
      end
    end
    chk("meas_valid", bus.meas_valid, ev_mv[cyc]);
    chk("high_cnt", bus.high_cnt, exp_h);
    chk("period_cnt", bus.period_cnt, exp_p);
    chk("timeout", bus.timeout, exp_to);
    chk("duty", bus.duty, exp_duty);
    chk("duty_valid", bus.duty_valid, dv);
  endtask

  task automatic step(input bit v);
    @(negedge clk);
    if (cyc + 10 >= NC) begin
      errors++;
      $display("FAIL cycle_budget observed %0d expected <%0d", cyc, NC - 10);
      $fatal(1, "cycle budget exhausted");
    end
    check_cycle();
    model_drive(v);
    bus.pwm_in = v;
    cyc++;
  endtask

  task automatic pulses(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (h) step(1'b1);
      repeat (p - h) step(1'b0);
    end
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) step(v);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_high"}, bus.high_cnt, 0);
    chk({tag, "_period"}, bus.period_cnt, 0);
    chk({tag, "_mv"}, bus.meas_valid, 0);
    chk({tag, "_to"}, bus.timeout, 0);
    chk({tag, "_duty"}, bus.duty, 0);
    chk({tag, "_dv"}, bus.duty_valid, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      ev_mv[cyc+i] = 0; ev_toset[cyc+i] = 0; ev_toclr[cyc+i] = 0;
    end
    have_ref = 0; in_low = 0; last_v = 0;
    exp_h = 0; exp_p = 0; exp_duty = 0; exp_to = 0;
    rst_idx = cyc;
  endtask

  initial begin
    int h, p, sel;
    bus.pwm_in = 1'b0;
    #2 reset = 1'b0;
    #1 check_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Steady H=3, P=10: duty 48/10 = 4
    pulses(3, 10, 6);
    chk("steady_high", bus.high_cnt, 3);
    chk("steady_period", bus.period_cnt, 10);

    // Generator-style loopback: duty code 7 on a 16-cycle period
    pulses(7, 16, 4);
    chk("gen_period", bus.period_cnt, 16);
    chk("gen_duty", bus.duty, DUTY_EN ? 7 : 0);

    // Minimum period: divider restarts continuously
    pulses(1, 2, 20);
    chk("min_high", bus.high_cnt, 1);

    // Stuck high -> timeout, then recovery
    hold(1'b1, 300);
    chk("to_stuck", bus.timeout, 1);
    hold(1'b0, 3);
    pulses(2, 5, 3);
    chk("to_clear", bus.timeout, 0);
    chk("to_recover_p", bus.period_cnt, 5);

    // Edges just inside the saturation limit
    hold(1'b0, 5);
    hold(1'b1, 254);
    hold(1'b0, 1);
    hold(1'b1, 2);
    hold(1'b0, 3);
    chk("edge_high", bus.high_cnt, 254);
    chk("edge_period", bus.period_cnt, 255);
    chk("edge_to", bus.timeout, 0);

    // Reset in the middle of a HIGH phase, pin still high at release
    hold(1'b0, 4);
    hold(1'b1, 6);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 check_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_drive(1'b1);
    cyc++;
    pulses(4, 9, 3);

    // Randomised trains and long holds
    for (int s = 0; s < 30; s++) begin
      sel = $urandom_range(0, 7);
      if (sel == 7) begin
        hold(1'($urandom_range(0, 1)), $urandom_range(200, 300));
      end else begin
        h = $urandom_range(1, 12);
        p = h + $urandom_range(1, 12);
        pulses(h, p, $urandom_range(2, 6));
      end
    end
    hold(1'b0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
